// File: rtl/dram_timing_ctrl_mb.sv
// Multi-bank DRAM timing controller: per-bank elapsed-cycle timers, a shared
// data-bus sequencer and a global refresh-interval timer, all outputs registered.
module dram_timing_ctrl_mb #(
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 8,
    parameter int REFI_W    = 12,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_CL      = 6,
    parameter int T_CWL     = 5,
    parameter int T_BURST   = 4,
    parameter int T_WR      = 6,
    parameter int T_RFC     = 32,
    parameter int T_REFI    = 780,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_type,
    input  logic [BANK_W-1:0]    cmd_bank,
    output logic [NUM_BANKS-1:0] tACT_done,
    output logic [NUM_BANKS-1:0] tPRE_done,
    output logic [NUM_BANKS-1:0] tRD_done,
    output logic [NUM_BANKS-1:0] tWR_done,
    output logic [NUM_BANKS-1:0] tWRITE_WAIT_done,
    output logic                 tREF_done,
    output logic                 rf_req,
    output logic                 rd_en,
    output logic                 wr_en,
    output logic                 clear,
    output logic [NUM_BANKS-1:0] bank_busy,
    output logic                 cmd_err
);

    localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  L_RCD      = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0]  L_RP       = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0]  L_CL       = CNT_W'(T_CL);
    localparam logic [CNT_W-1:0]  L_CWL      = CNT_W'(T_CWL);
    localparam logic [CNT_W-1:0]  L_RD_END   = CNT_W'(T_CL + T_BURST);
    localparam logic [CNT_W-1:0]  L_WR_END   = CNT_W'(T_CWL + T_BURST);
    localparam logic [CNT_W-1:0]  L_WW_END   = CNT_W'(T_CWL + T_BURST + T_WR);
    localparam logic [CNT_W-1:0]  L_RFC      = CNT_W'(T_RFC);
    localparam logic [REFI_W-1:0] ONE_R      = REFI_W'(1);
    localparam logic [REFI_W-1:0] L_REFI_MAX = REFI_W'(T_REFI - 1);
    localparam logic [BANK_W:0]   NB_C       = (BANK_W + 1)'(NUM_BANKS);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
        CMD_WR  = 3'd3, CMD_PRE = 3'd4, CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        OP_ACT = 2'd0, OP_PRE = 2'd1, OP_RD = 2'd2, OP_WR = 2'd3
    } op_e;

    // A bank timer stays active up to and including its last strobe cycle.
    function automatic logic [CNT_W-1:0] bank_final(input op_e op);
        case (op)
            OP_ACT:  bank_final = L_RCD;
            OP_PRE:  bank_final = L_RP;
            OP_RD:   bank_final = L_RD_END;
            OP_WR:   bank_final = L_WW_END;
            default: bank_final = L_RCD;
        endcase
    endfunction

    logic [NUM_BANKS-1:0] bank_act_q, bank_act_d;
    logic [CNT_W-1:0]     bank_el_q [NUM_BANKS];
    logic [CNT_W-1:0]     bank_el_d [NUM_BANKS];
    op_e                  bank_op_q [NUM_BANKS];
    op_e                  bank_op_d [NUM_BANKS];
    logic                 bus_act_q, bus_act_d;
    logic [CNT_W-1:0]     bus_el_q, bus_el_d;
    logic                 bus_rd_q, bus_rd_d;
    logic                 ref_act_q, ref_act_d;
    logic [CNT_W-1:0]     ref_el_q, ref_el_d;
    logic [REFI_W-1:0]    refi_q, refi_d;
    logic                 rf_req_q, rf_req_d;

    logic [NUM_BANKS-1:0] act_done_q, act_done_d;
    logic [NUM_BANKS-1:0] pre_done_q, pre_done_d;
    logic [NUM_BANKS-1:0] rd_done_q, rd_done_d;
    logic [NUM_BANKS-1:0] wr_done_q, wr_done_d;
    logic [NUM_BANKS-1:0] ww_done_q, ww_done_d;
    logic [NUM_BANKS-1:0] busy_q, busy_d;
    logic                 ref_done_q, ref_done_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 clear_q, clear_d;
    logic                 cmd_err_q, cmd_err_d;

    logic                 bank_idle_s;
    logic                 take_bank_s, take_bus_s, take_ref_s;
    op_e                  new_op_s;

    // Next-state: advance running timers, then arbitrate the incoming command.
    always_comb begin
        bank_act_d = bank_act_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_el_d[b] = bank_el_q[b];
            bank_op_d[b] = bank_op_q[b];
            if (bank_act_q[b]) begin
                if (bank_el_q[b] == bank_final(bank_op_q[b])) begin
                    bank_act_d[b] = 1'b0;
                    bank_el_d[b]  = {CNT_W{1'b0}};
                end else begin
                    bank_el_d[b]  = bank_el_q[b] + ONE_C;
                end
            end else begin
                bank_el_d[b] = bank_el_q[b];
            end
        end

        bus_act_d = bus_act_q;
        bus_el_d  = bus_el_q;
        bus_rd_d  = bus_rd_q;
        if (bus_act_q) begin
            if (bus_el_q == (bus_rd_q ? L_RD_END : L_WR_END)) begin
                bus_act_d = 1'b0;
                bus_el_d  = {CNT_W{1'b0}};
            end else begin
                bus_el_d  = bus_el_q + ONE_C;
            end
        end else begin
            bus_el_d = bus_el_q;
        end

        ref_act_d = ref_act_q;
        ref_el_d  = ref_el_q;
        if (ref_act_q) begin
            if (ref_el_q == L_RFC) begin
                ref_act_d = 1'b0;
                ref_el_d  = {CNT_W{1'b0}};
            end else begin
                ref_el_d  = ref_el_q + ONE_C;
            end
        end else begin
            ref_el_d = ref_el_q;
        end

        // Out-of-range banks fail the range test before the busy lookup matters.
        bank_idle_s = ({1'b0, cmd_bank} < NB_C) && !bank_act_q[cmd_bank];
        take_bank_s = 1'b0;
        take_bus_s  = 1'b0;
        take_ref_s  = 1'b0;
        new_op_s    = OP_ACT;
        cmd_err_d   = 1'b0;
        if (cmd_valid) begin
            case (cmd_type)
                CMD_NOP: cmd_err_d = 1'b0;
                CMD_ACT, CMD_PRE: begin
                    new_op_s = (cmd_type == CMD_ACT) ? OP_ACT : OP_PRE;
                    if (!ref_act_q && bank_idle_s) begin
                        take_bank_s = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_RD, CMD_WR: begin
                    new_op_s = (cmd_type == CMD_RD) ? OP_RD : OP_WR;
                    if (!ref_act_q && bank_idle_s && !bus_act_q) begin
                        take_bank_s = 1'b1;
                        take_bus_s  = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_REF: begin
                    if (!ref_act_q && !(|bank_act_q)) begin
                        take_ref_s = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: cmd_err_d = 1'b1;
            endcase
        end else begin
            cmd_err_d = 1'b0;
        end

        if (take_bank_s) begin
            bank_act_d[cmd_bank] = 1'b1;
            bank_el_d[cmd_bank]  = ONE_C;
            bank_op_d[cmd_bank]  = new_op_s;
        end else begin
            bank_act_d = bank_act_d;
        end
        if (take_bus_s) begin
            bus_act_d = 1'b1;
            bus_el_d  = ONE_C;
            bus_rd_d  = (new_op_s == OP_RD);
        end else begin
            bus_act_d = bus_act_d;
        end

        refi_d   = (refi_q == L_REFI_MAX) ? refi_q : refi_q + ONE_R;
        rf_req_d = rf_req_q | (refi_q == L_REFI_MAX);
        if (take_ref_s) begin
            ref_act_d = 1'b1;
            ref_el_d  = ONE_C;
            refi_d    = {REFI_W{1'b0}};
            rf_req_d  = 1'b0;
        end else begin
            ref_act_d = ref_act_d;
        end
    end

    // Output decode from next state so every strobe is a plain register.
    always_comb begin
        act_done_d = {NUM_BANKS{1'b0}};
        pre_done_d = {NUM_BANKS{1'b0}};
        rd_done_d  = {NUM_BANKS{1'b0}};
        wr_done_d  = {NUM_BANKS{1'b0}};
        ww_done_d  = {NUM_BANKS{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            act_done_d[b] = bank_act_d[b] && (bank_op_d[b] == OP_ACT) && (bank_el_d[b] == L_RCD);
            pre_done_d[b] = bank_act_d[b] && (bank_op_d[b] == OP_PRE) && (bank_el_d[b] == L_RP);
            rd_done_d[b]  = bank_act_d[b] && (bank_op_d[b] == OP_RD)  && (bank_el_d[b] == L_RD_END);
            wr_done_d[b]  = bank_act_d[b] && (bank_op_d[b] == OP_WR)  && (bank_el_d[b] == L_WR_END);
            ww_done_d[b]  = bank_act_d[b] && (bank_op_d[b] == OP_WR)  && (bank_el_d[b] == L_WW_END);
        end
        busy_d     = bank_act_d | {NUM_BANKS{ref_act_d}};
        ref_done_d = ref_act_d && (ref_el_d == L_RFC);
        rd_en_d    = bus_act_d && bus_rd_d && (bus_el_d >= L_CL) && (bus_el_d < L_RD_END);
        wr_en_d    = bus_act_d && !bus_rd_d && (bus_el_d >= L_CWL) && (bus_el_d < L_WR_END);
        clear_d    = bus_act_d && (bus_el_d == (bus_rd_d ? L_RD_END : L_WR_END));
    end

    // State and output registers; reset abandons all timers outright.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_act_q <= {NUM_BANKS{1'b0}};
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_el_q[b] <= {CNT_W{1'b0}};
                bank_op_q[b] <= OP_ACT;
            end
            bus_act_q  <= 1'b0;
            bus_el_q   <= {CNT_W{1'b0}};
            bus_rd_q   <= 1'b0;
            ref_act_q  <= 1'b0;
            ref_el_q   <= {CNT_W{1'b0}};
            refi_q     <= {REFI_W{1'b0}};
            rf_req_q   <= 1'b0;
            act_done_q <= {NUM_BANKS{1'b0}};
            pre_done_q <= {NUM_BANKS{1'b0}};
            rd_done_q  <= {NUM_BANKS{1'b0}};
            wr_done_q  <= {NUM_BANKS{1'b0}};
            ww_done_q  <= {NUM_BANKS{1'b0}};
            busy_q     <= {NUM_BANKS{1'b0}};
            ref_done_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            clear_q    <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            bank_act_q <= bank_act_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_el_q[b] <= bank_el_d[b];
                bank_op_q[b] <= bank_op_d[b];
            end
            bus_act_q  <= bus_act_d;
            bus_el_q   <= bus_el_d;
            bus_rd_q   <= bus_rd_d;
            ref_act_q  <= ref_act_d;
            ref_el_q   <= ref_el_d;
            refi_q     <= refi_d;
            rf_req_q   <= rf_req_d;
            act_done_q <= act_done_d;
            pre_done_q <= pre_done_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            ww_done_q  <= ww_done_d;
            busy_q     <= busy_d;
            ref_done_q <= ref_done_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            clear_q    <= clear_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign tACT_done        = act_done_q;
    assign tPRE_done        = pre_done_q;
    assign tRD_done         = rd_done_q;
    assign tWR_done         = wr_done_q;
    assign tWRITE_WAIT_done = ww_done_q;
    assign tREF_done        = ref_done_q;
    assign rf_req           = rf_req_q;
    assign rd_en            = rd_en_q;
    assign wr_en            = wr_en_q;
    assign clear            = clear_q;
    assign bank_busy        = busy_q;
    assign cmd_err          = cmd_err_q;

endmodule
